// File: rtl/dac_pkg.sv
// Shared types and sizing helpers for the segmented DAC decoder.
// The element-rotation build option is selected with the DEC_DWA_EN macro.
package dac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Number of unary segment lines driven by an msb_w-bit field.
  function automatic int calc_nt(input int msb_w);
    return (1 << msb_w) - 1;
  endfunction

  function automatic int calc_cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/seg_dac_decoder_therm_encoder.sv
// Combinational m -> N_T-line unary code, starting at rotation pointer p.
// Line (p+k) mod N_T is lit for k = 0..m-1; p = 0 gives the plain thermometer code.
module therm_encoder
  import dac_pkg::*;
#(
  parameter int MSB_W = 3,
  localparam int N_T = calc_nt(MSB_W)
) (
  input  logic [MSB_W-1:0] m,
  input  logic [MSB_W-1:0] p,
  output logic [N_T-1:0]   therm
);

  int off;

  // Each line is lit when its distance past the pointer falls below m.
  always_comb begin
    therm = '0;
    off   = 0;
    for (int i = 0; i < N_T; i++) begin
      off      = (i >= int'(p)) ? (i - int'(p)) : (i + N_T - int'(p));
      therm[i] = (off < int'(m));
    end
  end

endmodule

// File: rtl/seg_dac_decoder.sv
// Serial MSB-first word deserialiser feeding a thermometer/binary segmented DAC.
// Define DEC_DWA_EN to rotate the thermometer lines with data-weighted averaging.
module seg_dac_decoder
  import dac_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int MSB_W = 3,
  localparam int N_T = calc_nt(MSB_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serial_in,
  input  logic                   sync_in,
  output logic [N_T-1:0]         therm_out,
  output logic [BIN_W-MSB_W-1:0] bin_out,
  output logic                   word_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int CNT_W = calc_cnt_w(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  if (BIN_W < 2 || BIN_W > 16 || MSB_W < 1 || MSB_W > BIN_W - 1) begin : g_bad_params
    $error("seg_dac_decoder: illegal BIN_W/MSB_W combination");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-2:0]   shreg;
  logic [BIN_W-1:0]   word_full;
  logic [MSB_W-1:0]   m;
  logic [MSB_W-1:0]   ptr;
  logic [N_T-1:0]     therm_next;

  assign word_full = {shreg, serial_in};
  assign m         = word_full[BIN_W-1 -: MSB_W];

`ifdef DEC_DWA_EN
  localparam logic [MSB_W:0] NT_EXT = (MSB_W + 1)'(N_T);
  logic [MSB_W:0]   p_sum;
  logic [MSB_W-1:0] p_next;

  // p + m never exceeds 2*N_T-1, so one conditional subtract wraps it.
  always_comb begin
    p_sum  = {1'b0, ptr} + {1'b0, m};
    p_next = (p_sum >= NT_EXT) ? MSB_W'(p_sum - NT_EXT) : p_sum[MSB_W-1:0];
  end
`else
  assign ptr = '0;
`endif

  therm_encoder #(.MSB_W(MSB_W)) u_enc (
    .m     (m),
    .p     (ptr),
    .therm (therm_next)
  );

  // A sync seen mid-frame restarts framing on the current bit and drops the partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      therm_out  <= '0;
      bin_out    <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef DEC_DWA_EN
      ptr        <= '0;
`endif
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_in) begin
            shreg <= (BIN_W - 1)'(serial_in);
            cnt   <= CNT_W'(1);
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (sync_in) begin
            frame_err <= 1'b1;
            shreg     <= (BIN_W - 1)'(serial_in);
            cnt       <= CNT_W'(1);
          end else if (cnt == LAST_CNT) begin
            therm_out  <= therm_next;
            bin_out    <= word_full[BIN_W-MSB_W-1:0];
            word_valid <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
`ifdef DEC_DWA_EN
            ptr        <= p_next;
`endif
          end else begin
            shreg <= word_full[BIN_W-2:0];
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_dac_decoder.sv
// Directed self-checking bench for seg_dac_decoder (BIN_W=8, MSB_W=3).
// Expected values for rotated codes are selected with DEC_DWA_EN.
module tb_seg_dac_decoder;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       sync_in;
  logic [6:0] therm_out;
  logic [4:0] bin_out;
  logic       word_valid;
  logic       frame_err;
  logic       busy;

  int checks;
  int fails;
  logic seen_valid;

  seg_dac_decoder #(.BIN_W(8), .MSB_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .sync_in    (sync_in),
    .therm_out  (therm_out),
    .bin_out    (bin_out),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b);
    @(negedge clk);
    sync_in   = s;
    serial_in = b;
  endtask

  // Sample just after a rising edge, once the registers have settled.
  task automatic waitSample();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) drive(i == 7, w[i]);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    sync_in = 1'b0;
    serial_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst = 1'b1;
    sync_in = 1'b0;
    serial_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_therm", 32'(therm_out), 32'h00);
    checkOutput("reset_bin", 32'(bin_out), 32'h00);
    checkOutput("reset_valid", 32'(word_valid), 32'h0);
    checkOutput("reset_err", 32'(frame_err), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);

    // 0xB5: m=5 -> 0011111, LSBs 10101
    applyStimulus(8'hB5);
    checkOutput("b5_busy_mid", 32'(busy), 32'h1);
    checkOutput("b5_no_early_valid", 32'(word_valid), 32'h0);
    waitSample();
    checkOutput("b5_valid", 32'(word_valid), 32'h1);
    checkOutput("b5_therm", 32'(therm_out), 32'h1F);
    checkOutput("b5_bin", 32'(bin_out), 32'h15);
    checkOutput("b5_busy_done", 32'(busy), 32'h0);
    waitSample();
    checkOutput("b5_valid_pulse", 32'(word_valid), 32'h0);
    checkOutput("b5_therm_hold", 32'(therm_out), 32'h1F);

    // Back-to-back 0xB5 frames with zero gap
    doReset();
    applyStimulus(8'hB5);
    waitSample();
    checkOutput("b2b_first_valid", 32'(word_valid), 32'h1);
    checkOutput("b2b_first_therm", 32'(therm_out), 32'h1F);
    applyStimulus(8'hB5);
    waitSample();
    checkOutput("b2b_second_valid", 32'(word_valid), 32'h1);
`ifdef DEC_DWA_EN
    checkOutput("b2b_second_therm", 32'(therm_out), 32'h67);
`else
    checkOutput("b2b_second_therm", 32'(therm_out), 32'h1F);
`endif
    checkOutput("b2b_second_bin", 32'(bin_out), 32'h15);

    // Extreme codes, then 0xB5 to show the pointer did not move
    doReset();
    applyStimulus(8'h00);
    waitSample();
    checkOutput("zero_valid", 32'(word_valid), 32'h1);
    checkOutput("zero_therm", 32'(therm_out), 32'h00);
    checkOutput("zero_bin", 32'(bin_out), 32'h00);
    applyStimulus(8'hFF);
    waitSample();
    checkOutput("full_valid", 32'(word_valid), 32'h1);
    checkOutput("full_therm", 32'(therm_out), 32'h7F);
    checkOutput("full_bin", 32'(bin_out), 32'h1F);
    applyStimulus(8'hB5);
    waitSample();
    checkOutput("after_ext_therm", 32'(therm_out), 32'h1F);

    // Truncated frame: sync again at bit 4, new word 0x6A (m=3, LSBs 01010)
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    waitSample();
    checkOutput("trunc_err", 32'(frame_err), 32'h1);
    checkOutput("trunc_no_valid", 32'(word_valid), 32'h0);
    checkOutput("trunc_therm_hold", 32'(therm_out), 32'h1F);
    checkOutput("trunc_bin_hold", 32'(bin_out), 32'h15);
    checkOutput("trunc_busy", 32'(busy), 32'h1);
    for (int i = 6; i >= 0; i--) drive(1'b0, 1'((8'h6A >> i) & 1));
    waitSample();
    checkOutput("resync_valid", 32'(word_valid), 32'h1);
    checkOutput("resync_err_clear", 32'(frame_err), 32'h0);
`ifdef DEC_DWA_EN
    checkOutput("resync_therm", 32'(therm_out), 32'h61);
`else
    checkOutput("resync_therm", 32'(therm_out), 32'h07);
`endif
    checkOutput("resync_bin", 32'(bin_out), 32'h0A);

    // Reset during bit 5 aborts the frame silently
    drive(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    waitSample();
    checkOutput("midrst_therm", 32'(therm_out), 32'h00);
    checkOutput("midrst_bin", 32'(bin_out), 32'h00);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'(i & 1));
      waitSample();
      seen_valid = seen_valid | word_valid | busy;
    end
    checkOutput("nosync_no_activity", 32'(seen_valid), 32'h0);

    // Idle toggling without sync holds the last word
    applyStimulus(8'hB5);
    waitSample();
    checkOutput("idle_setup_therm", 32'(therm_out), 32'h1F);
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'(~i & 1));
      waitSample();
      seen_valid = seen_valid | word_valid | frame_err;
    end
    checkOutput("idle_no_pulse", 32'(seen_valid), 32'h0);
    checkOutput("idle_therm_hold", 32'(therm_out), 32'h1F);
    checkOutput("idle_bin_hold", 32'(bin_out), 32'h15);
    checkOutput("idle_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
